// File: rtl/twiddle_mul_sched.sv
// twiddle_mul_sched
// Time-shares one external DW x TW fixed-point real multiplier between two
// butterfly lanes to perform complex twiddle multiplication y = x * w.
// A round-robin arbiter grants one lane at a time. The granted operands are
// latched, and the four real products are sequenced through the multiplier
// port one per cycle. The products are combined into a saturated complex
// result, and that result is returned tagged with the lane id.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid / req_ready  per-lane request handshake (ready is one-hot or zero)
//   x_re*/x_im*            per-lane data operand (DW bits, two's complement)
//   w_re*/w_im*            per-lane twiddle (TW bits, 7 fractional bits)
//   mul_a, mul_b, mul_p    shared multiplier operands and combinational product
//   out_valid/out_ready    result handshake
//   out_id, y_re, y_im     issuing lane and saturated complex result
//   busy                   high whenever the sequencer is not idle
module twiddle_mul_sched #(
  parameter int DW = 17,
  parameter int TW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic signed [DW-1:0] x_re0,
  input  logic signed [DW-1:0] x_im0,
  input  logic signed [DW-1:0] x_re1,
  input  logic signed [DW-1:0] x_im1,
  input  logic signed [TW-1:0] w_re0,
  input  logic signed [TW-1:0] w_im0,
  input  logic signed [TW-1:0] w_re1,
  input  logic signed [TW-1:0] w_im1,
  output logic signed [DW-1:0] mul_a,
  output logic signed [TW-1:0] mul_b,
  input  logic signed [DW-1:0] mul_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_id,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, AC, BD, AD, BC, OUT} state_t;

  state_t               state;
  logic                 last;
  logic                 id;
  logic signed [DW-1:0] x_re_q, x_im_q;
  logic signed [TW-1:0] w_re_q, w_im_q;
  logic signed [DW-1:0] p_ac, p_bd, p_ad;
  logic                 grant;
  logic [1:0]           ready_c;
  logic signed [DW:0]   diff, sum;

  // Clamp a DW+1 bit value into DW bits. Overflow shows up as the top two
  // bits disagreeing, and the top bit then gives the direction.
  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      return v[DW-1:0];
  endfunction

  // Round-robin arbitration. On a tie the lane not served last wins, so
  // last resetting to 1 lets lane 0 win the first tie.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    grant   = 1'b0;
    ready_c = 2'b00;
    if (req_valid == 2'b11) grant = ~last;
    else                    grant = req_valid[1];
    // Held low during reset so a waiting requester cannot see a grant.
    if (state == IDLE && !rst && req_valid != 2'b00) ready_c[grant] = 1'b1;
  end

  assign req_ready = ready_c;

  // One operand pair per product state, and zero everywhere else.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      AC:      begin mul_a = x_re_q; mul_b = w_re_q; end
      BD:      begin mul_a = x_im_q; mul_b = w_im_q; end
      AD:      begin mul_a = x_re_q; mul_b = w_im_q; end
      BC:      begin mul_a = x_im_q; mul_b = w_re_q; end
      default: begin mul_a = '0;     mul_b = '0;     end
    endcase
  end

  // Both combinations are formed at DW+1 bits. In BC the last product p_bc
  // is still on mul_p and has not been registered yet.
  assign diff = {p_ac[DW-1], p_ac} - {p_bd[DW-1], p_bd};
  assign sum  = {p_ad[DW-1], p_ad} + {mul_p[DW-1], mul_p};

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      id     <= 1'b0;
      x_re_q <= '0;
      x_im_q <= '0;
      w_re_q <= '0;
      w_im_q <= '0;
      p_ac   <= '0;
      p_bd   <= '0;
      p_ad   <= '0;
      y_re   <= '0;
      y_im   <= '0;
      out_id <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then updates from values sampled at the same edge.
      case (state)
        IDLE: begin
          if (|(req_valid & ready_c)) begin
            x_re_q <= grant ? x_re1 : x_re0;
            x_im_q <= grant ? x_im1 : x_im0;
            w_re_q <= grant ? w_re1 : w_re0;
            w_im_q <= grant ? w_im1 : w_im0;
            id     <= grant;
            last   <= grant;
            state  <= AC;
          end
        end
        AC: begin p_ac <= mul_p; state <= BD; end
        BD: begin p_bd <= mul_p; state <= AD; end
        AD: begin p_ad <= mul_p; state <= BC; end
        BC: begin
          y_re   <= sat(diff);
          y_im   <= sat(sum);
          out_id <= id;
          state  <= OUT;
        end
        OUT:     if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_mul_sched.sv
// Self-checking bench for twiddle_mul_sched. The bench supplies the shared
// multiplier as p = (a*b) >>> 7. Directed and randomized requests are checked
// against a reference model that computes each result from plain complex
// arithmetic plus a round-robin pointer.
module tb_twiddle_mul_sched;
  localparam int DW = 17;
  localparam int TW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid, req_ready;
  logic signed [DW-1:0] x_re0, x_im0, x_re1, x_im1;
  logic signed [TW-1:0] w_re0, w_im0, w_re1, w_im1;
  logic signed [DW-1:0] mul_a, mul_p, y_re, y_im;
  logic signed [TW-1:0] mul_b;
  logic                 out_valid, out_ready, out_id, busy;

  int checks = 0;
  int errors = 0;
  bit last_m;
  longint t_out, t_prev;

  always #5 clk = ~clk;

  twiddle_mul_sched #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .x_re0(x_re0), .x_im0(x_im0), .x_re1(x_re1), .x_im1(x_im1),
    .w_re0(w_re0), .w_im0(w_im0), .w_re1(w_re1), .w_im1(w_im1),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .y_re(y_re), .y_im(y_im), .busy(busy)
  );

  function automatic logic signed [DW-1:0] mf(input logic signed [DW-1:0] a,
                                              input logic signed [TW-1:0] b);
    longint p;
    p = (longint'(a) * longint'(b)) >>> 7;
    return p[DW-1:0];
  endfunction

  assign mul_p = mf(mul_a, mul_b);

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input bit l, input int xr, input int xi,
                          input int wr, input int wi);
    if (l) begin
      x_re1 = DW'(xr); x_im1 = DW'(xi); w_re1 = TW'(wr); w_im1 = TW'(wi);
    end else begin
      x_re0 = DW'(xr); x_im0 = DW'(xi); w_re0 = TW'(wr); w_im0 = TW'(wi);
    end
  endtask

  // Issue one request pattern from a negedge and follow the whole operation
  // until the result has been released. The task returns at the negedge of
  // the following IDLE cycle.
  task automatic run_op(input logic [1:0] rv, input int stall, input bit drop_req,
                        output longint t_res);
    bit g;
    logic signed [DW-1:0] xr, xi;
    logic signed [TW-1:0] wr, wi;
    longint er, ei;
    logic signed [DW-1:0] ea[4];
    logic signed [TW-1:0] eb[4];
    req_valid = rv;
    out_ready = (stall == 0);
    #1;
    g = (rv == 2'b11) ? ~last_m : rv[1];
    check("req_ready_grant", req_ready, 64'(2'b01 << g));
    xr = g ? x_re1 : x_re0;  xi = g ? x_im1 : x_im0;
    wr = g ? w_re1 : w_re0;  wi = g ? w_im1 : w_im0;
    er = sat(longint'(mf(xr, wr)) - longint'(mf(xi, wi)));
    ei = sat(longint'(mf(xr, wi)) + longint'(mf(xi, wr)));
    ea = '{xr, xi, xr, xi};
    eb = '{wr, wi, wi, wr};
    last_m = g;
    @(posedge clk);
    #1;
    if (drop_req) req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mul_a", mul_a, ea[k]);
      check("mul_b", mul_b, eb[k]);
      check("valid_early", out_valid, 0);
      check("ready_busy", req_ready, 0);
      check("busy", busy, 1);
    end
    @(negedge clk);
    t_res = $time;
    check("out_valid", out_valid, 1);
    check("y_re", y_re, er);
    check("y_im", y_im, ei);
    check("out_id", out_id, g);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_y_re", y_re, er);
      check("stall_y_im", y_im, ei);
      check("stall_id", out_id, g);
      check("stall_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("released", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b0;
    set_lane(0, 0, 0, 0, 0);
    set_lane(1, 0, 0, 0, 0);
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_y_re", y_re, 0);
    check("rst_y_im", y_im, 0);
    check("rst_id", out_id, 0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    // Single lane-0 request: (1024,0)*(64,0) = (512,0)
    set_lane(0, 1024, 0, 64, 0);
    run_op(2'b01, 0, 1, t_out);
    check("single_y_re", y_re, 512);
    check("single_y_im", y_im, 0);

    // Complex product: (256,256)*(64,64) = (0,256)
    set_lane(1, 256, 256, 64, 64);
    run_op(2'b10, 0, 1, t_out);
    check("cplx_y_re", y_re, 0);
    check("cplx_y_im", y_im, 256);

    // Positive saturation of the real part
    set_lane(0, 65535, -65536, 127, 127);
    run_op(2'b01, 0, 1, t_out);
    check("sat_pos", y_re, 65535);

    // Negative saturation of the imaginary part
    set_lane(1, -65536, -65536, 127, 127);
    run_op(2'b10, 0, 1, t_out);
    check("sat_neg", y_im, -65536);

    // Both lanes requesting continuously: the grants alternate and the
    // results come out 6 cycles apart.
    set_lane(0, 3000, -700, 90, -45);
    set_lane(1, -12000, 5000, -128, 33);
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 0, 0, t_out);
      if (i > 0) check("issue_interval", t_out - t_prev, 60);
      t_prev = t_out;
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Backpressure for 10 cycles with both lanes waiting
    run_op(2'b11, 10, 0, t_out);
    req_valid = 2'b00;
    @(negedge clk);

    // Reset asserted in state AD
    set_lane(0, 4000, 4000, 50, 50);
    req_valid = 2'b01;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("ad_mul_a", mul_a, 4000);
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_mul_a", mul_a, 0);
    check("arst_mul_b", mul_b, 0);
    check("arst_ready", req_ready, 0);
    check("arst_y_re", y_re, 0);
    check("arst_y_im", y_im, 0);
    check("arst_id", out_id, 0);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    last_m = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end
    set_lane(0, 700, 800, 20, -30);
    set_lane(1, -900, 100, 10, 40);
    run_op(2'b11, 0, 1, t_out);
    check("post_rst_lane", out_id, 0);

    // Randomized requests, operands and stalls
    for (int i = 0; i < 40; i++) begin
      set_lane(0, int'($urandom_range(0, 131071)) - 65536,
                  int'($urandom_range(0, 131071)) - 65536,
                  int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128);
      set_lane(1, int'($urandom_range(0, 131071)) - 65536,
                  int'($urandom_range(0, 131071)) - 65536,
                  int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128);
      run_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1, t_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
